// File: rtl/mux_stream_arb_if.sv
// Stream bundle between N producer channels, the arbiter and one consumer.
// The master side drives the producer data/valid and the consumer ready;
// the slave side is the arbiter itself.
interface mux_stream_arb_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int SEL_W = $clog2(DEPTH);

    logic [WIDTH*DEPTH-1:0] in_data;
    logic [DEPTH-1:0]       in_valid;
    logic [DEPTH-1:0]       in_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SEL_W-1:0]       out_chan;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_stream_arb.sv
// N:1 registered stream multiplexer. A fixed-select or round-robin grant
// picks one valid producer; the winning word is captured in a single output
// register tagged with its source channel, which holds under back-pressure.
module mux_stream_arb #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int SEL_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    mux_stream_arb_if.slave  s,
    output logic             sel_err,
    output logic [31:0]      xfer_cnt
);
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] chan_q;
    logic             vld_q;
    logic [SEL_W-1:0] rr_ptr;

    logic             load;
    logic             xfer;
    logic             sel_oob;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [DEPTH-1:0] ready;

    // Output register can accept a word when empty or being drained now.
    assign load    = ~vld_q | s.out_ready;
    assign xfer    = ~rst & load & grant_vld;
    assign sel_oob = (mode == 1'b0) && (int'(sel) >= DEPTH);

    // Grant selection: fixed index, or first valid channel after rr_ptr.
    always_comb begin
        int cand;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        cand       = 0;
        if (mode == 1'b0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel == SEL_W'(i) && s.in_valid[i]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SEL_W'(i);
                    grant_data = s.in_data[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            // rr_ptr itself is reached last (k == DEPTH), giving it lowest priority.
            for (int k = 1; k <= DEPTH; k++) begin
                cand = int'(rr_ptr) + k;
                if (cand >= DEPTH) begin
                    cand = cand - DEPTH;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (!grant_vld && cand == i && s.in_valid[i]) begin
                        grant_vld  = 1'b1;
                        grant_idx  = SEL_W'(i);
                        grant_data = s.in_data[i*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // One-hot ready to the granted producer only, suppressed during reset.
    always_comb begin
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = xfer && (grant_idx == SEL_W'(i));
        end
    end

    assign s.in_ready  = ready;
    assign s.out_data  = data_q;
    assign s.out_chan  = chan_q;
    assign s.out_valid = vld_q;

    // Output register, transfer counter, round-robin pointer and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            chan_q   <= '0;
            vld_q    <= 1'b0;
            rr_ptr   <= SEL_W'(DEPTH - 1);
            sel_err  <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            sel_err <= sel_oob;
            if (xfer) begin
                data_q   <= grant_data;
                chan_q   <= grant_idx;
                vld_q    <= 1'b1;
                xfer_cnt <= xfer_cnt + 32'd1;
                if (mode) begin
                    rr_ptr <= grant_idx;
                end
            end else if (vld_q && s.out_ready) begin
                vld_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_stream_arb.sv
// Bench for mux_stream_arb: a 16-channel instance checked every cycle against
// a queue-free behavioural model, plus a 10-channel instance for the
// out-of-range select case.
module tb_mux_stream_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mode;
    logic [3:0]  sel;
    logic        sel_err;
    logic [31:0] xfer_cnt;

    logic        mode10;
    logic [3:0]  sel10;
    logic        sel_err10;
    logic [31:0] xfer_cnt10;

    mux_stream_arb_if #(.WIDTH(32), .DEPTH(16)) bus ();
    mux_stream_arb_if #(.WIDTH(8), .DEPTH(10)) bus10 ();

    mux_stream_arb #(.WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .s(bus),
        .sel_err(sel_err), .xfer_cnt(xfer_cnt)
    );

    mux_stream_arb #(.WIDTH(8), .DEPTH(10)) dut10 (
        .clk(clk), .rst(rst), .mode(mode10), .sel(sel10), .s(bus10),
        .sel_err(sel_err10), .xfer_cnt(xfer_cnt10)
    );

    int checks;
    int errors;

    // Reference model state
    bit          m_vld;
    logic [31:0] m_data;
    int          m_chan;
    int          m_ptr;
    logic [31:0] m_cnt;
    bit          m_err;
    int          pend_g;
    logic [15:0] pend_ready;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] valid;
        logic [15:0] exp_ready;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [31:0] v);
        logic [511:0] m;
        m = 512'hFFFF_FFFF << (i * 32);
        bus.in_data = (bus.in_data & ~m) | (512'(v) << (i * 32));
    endtask

    function automatic logic [31:0] get_ch(input int i);
        return 32'(bus.in_data >> (i * 32));
    endfunction

    function automatic bit vld_bit(input int c);
        return ((bus.in_valid >> c) & 16'h1) != 16'h0;
    endfunction

    // Specification rule for which producer wins this cycle (-1 = none).
    function automatic int ref_grant();
        if (!mode) begin
            if (int'(sel) < 16 && vld_bit(int'(sel))) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= 16; k++) begin
            int c;
            c = (m_ptr + k) % 16;
            if (vld_bit(c)) return c;
        end
        return -1;
    endfunction

    // Let inputs settle, then compare the combinational ready vector.
    task automatic settle();
        #1;
        pend_g = ref_grant();
        pend_ready = '0;
        if (!rst && !(m_vld && !bus.out_ready) && pend_g >= 0)
            pend_ready = 16'h1 << pend_g;
        chk("in_ready", 32'(bus.in_ready), 32'(pend_ready));
    endtask

    // Advance one clock, update the model, compare registered outputs.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_vld = 0; m_data = '0; m_chan = 0; m_cnt = '0; m_ptr = 15; m_err = 0;
        end else begin
            m_err = !mode && int'(sel) >= 16;
            if (pend_ready != 16'h0) begin
                m_data = get_ch(pend_g);
                m_chan = pend_g;
                m_vld  = 1;
                m_cnt  = m_cnt + 32'd1;
                if (mode) m_ptr = pend_g;
            end else if (m_vld && bus.out_ready) begin
                m_vld = 0;
            end
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
        chk("out_data", bus.out_data, m_data);
        chk("out_chan", 32'(bus.out_chan), 32'(m_chan));
        chk("xfer_cnt", xfer_cnt, m_cnt);
        chk("sel_err", 32'(sel_err), 32'(m_err));
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        logic [79:0] d10;
        int rr_exp [4];
        checks = 0; errors = 0;
        m_vld = 0; m_data = '0; m_chan = 0; m_ptr = 15; m_cnt = '0; m_err = 0;
        pend_g = -1; pend_ready = '0;

        tbl[0] = '{4'd5,  16'h0020, 16'h0020};
        tbl[1] = '{4'd5,  16'hFFDF, 16'h0000};
        tbl[2] = '{4'd0,  16'hFFFF, 16'h0001};
        tbl[3] = '{4'd15, 16'h8000, 16'h8000};
        tbl[4] = '{4'd15, 16'h7FFF, 16'h0000};
        tbl[5] = '{4'd9,  16'h0300, 16'h0200};

        rst = 1; mode = 0; sel = 0;
        bus.in_data = '0; bus.in_valid = '0; bus.out_ready = 0;
        for (int i = 0; i < 16; i++) set_ch(i, 32'hA5A5_0000 | 32'(i));
        mode10 = 0; sel10 = 0; bus10.in_valid = '0; bus10.out_ready = 1;
        d10 = '0;
        for (int i = 0; i < 10; i++) d10 = d10 | (80'(8'h50 + i) << (i * 8));
        bus10.in_data = d10;

        // Reset state
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_xfer_cnt", xfer_cnt, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_sel_err10", 32'(sel_err10), 32'd0);
        rst = 0;

        // DEPTH=10: out-of-range select, then the last legal channel
        sel10 = 4'd12; bus10.in_valid = 10'h3FF;
        step();
        chk("t5_oob_ready", 32'(bus10.in_ready), 32'd0);
        chk("t5_oob_err", 32'(sel_err10), 32'd1);
        chk("t5_oob_valid", 32'(bus10.out_valid), 32'd0);
        sel10 = 4'd9;
        settle();
        chk("t5_ready9", 32'(bus10.in_ready), 32'h200);
        tick();
        chk("t5_err_clear", 32'(sel_err10), 32'd0);
        chk("t5_valid9", 32'(bus10.out_valid), 32'd1);
        chk("t5_chan9", 32'(bus10.out_chan), 32'd9);
        chk("t5_data9", 32'(bus10.out_data), 32'h59);
        chk("t5_cnt", xfer_cnt10, 32'd1);
        bus10.in_valid = '0;

        // Fixed select of channel 5
        sel = 4'd5; bus.in_valid = 16'h0020; bus.out_ready = 1;
        settle();
        chk("t1_ready", 32'(bus.in_ready), 32'h20);
        tick();
        chk("t1_data", bus.out_data, 32'hA5A5_0005);
        chk("t1_chan", 32'(bus.out_chan), 32'd5);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_cnt", xfer_cnt, 32'd1);

        // Fixed-select vector table, each from an empty output register
        for (int t = 0; t < 6; t++) begin
            bus.in_valid = '0; bus.out_ready = 1;
            step();
            sel = tbl[t].sel; bus.in_valid = tbl[t].valid;
            settle();
            chk($sformatf("tbl%0d_ready", t), 32'(bus.in_ready), 32'(tbl[t].exp_ready));
            tick();
            chk($sformatf("tbl%0d_valid", t), 32'(bus.out_valid),
                (tbl[t].exp_ready != 16'h0) ? 32'd1 : 32'd0);
            if (tbl[t].exp_ready != 16'h0)
                chk($sformatf("tbl%0d_chan", t), 32'(bus.out_chan), 32'(tbl[t].sel));
        end

        // Round robin from reset, all channels valid
        rst = 1; bus.in_valid = '0;
        step();
        rst = 0; mode = 1; bus.in_valid = 16'hFFFF; bus.out_ready = 1;
        for (int i = 0; i < 17; i++) begin
            step();
            chk("t2_chan", 32'(bus.out_chan), 32'(i % 16));
            chk("t2_valid", 32'(bus.out_valid), 32'd1);
        end

        // Round robin with sparse requesters, pointer parked on 7
        bus.in_valid = 16'h0080;
        step();
        chk("t3_park7", 32'(bus.out_chan), 32'd7);
        bus.in_valid = 16'h1088;
        rr_exp = '{12, 3, 7, 12};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_order", 32'(bus.out_chan), 32'(rr_exp[i]));
        end

        // Back-pressure holds the output word and blocks all producers
        mode = 0; sel = 4'd1; bus.in_valid = 16'h0002;
        step();
        bus.out_ready = 0; sel = 4'd2; bus.in_valid = 16'h0004;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t4_ready_held", 32'(bus.in_ready), 32'd0);
            tick();
            chk("t4_chan_held", 32'(bus.out_chan), 32'd1);
            chk("t4_data_held", bus.out_data, 32'hA5A5_0001);
        end
        bus.out_ready = 1;
        settle();
        chk("t4_ready_rel", 32'(bus.in_ready), 32'h4);
        tick();
        chk("t4_chan2", 32'(bus.out_chan), 32'd2);

        // Reset while a word is stalled in the output register
        bus.out_ready = 0;
        step();
        rst = 1;
        step();
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_cnt", xfer_cnt, 32'd0);
        rst = 0; mode = 1; bus.in_valid = 16'hFFFF; bus.out_ready = 1;
        step();
        chk("t6_rr_first", 32'(bus.out_chan), 32'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(63) == 0);
            mode = 1'($urandom_range(1));
            sel  = 4'($urandom_range(15));
            bus.in_valid  = 16'($urandom) & 16'($urandom);
            bus.out_ready = ($urandom_range(3) != 0);
            set_ch($urandom_range(15), $urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
